// File: rtl/stream_mux_n.sv
// N-channel, W-bit registered stream multiplexer with valid/ready on every port.
// Default: explicit select via s. Define STREAM_MUX_RR_EN for round-robin arbitration (s ignored).
module stream_mux_n #(
  parameter  int N  = 4,
  parameter  int W  = 8,
  localparam int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  input  logic [SW-1:0]  s,
  output logic [W-1:0]   out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [SW-1:0]  out_ch
);

  logic          load;
  logic          grant_ok;
  logic [SW-1:0] grant;
  logic          accept;

  // The output register can take a new beat when empty or being drained this cycle.
  assign load = !out_valid || out_ready;

`ifdef STREAM_MUX_RR_EN
  logic [SW-1:0] ptr;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    grant_ok = 1'b0;
    grant    = '0;
    // Walk the search order backwards so the last hit is the first channel after ptr.
    for (int i = N - 1; i >= 0; i--) begin
      if (in_valid[(int'(ptr) + i) % N]) begin
        grant_ok = 1'b1;
        grant    = SW'((int'(ptr) + i) % N);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= (int'(grant) == N - 1) ? '0 : grant + SW'(1);
    end
  end

  // The select port has no function in round-robin mode.
  logic s_unused;
  assign s_unused = ^s;
`else
  always_comb begin
    grant_ok = (int'(s) < N);
    grant    = s;
  end
`endif

  assign accept = grant_ok && load && in_valid[grant];

  // Ready is forced low while reset is asserted, even though the empty register would allow a load.
  always_comb begin
    in_ready = '0;
    for (int k = 0; k < N; k++) begin
      in_ready[k] = rst_n && grant_ok && load && (int'(grant) == k);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= in_data[int'(grant)*W +: W];
      out_ch    <= grant;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_mux_n.sv
// Self-checking bench for stream_mux_n: behavioural model compared every cycle,
// directed literal scenarios, then randomized traffic. Follows STREAM_MUX_RR_EN like the RTL.
module tb_stream_mux_n;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int SW = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N*W-1:0] in_data = '0;
  logic [N-1:0]   in_valid = '0;
  logic [N-1:0]   in_ready;
  logic [SW-1:0]  s = '0;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [SW-1:0]  out_ch;

  // Three-channel instance for the out-of-range select case.
  logic [3*W-1:0] in_data3 = '0;
  logic [2:0]     in_valid3 = '0;
  logic [2:0]     in_ready3;
  logic [1:0]     s3 = '0;
  logic [W-1:0]   out_data3;
  logic           out_valid3;
  logic           out_ready3 = 1'b0;
  logic [1:0]     out_ch3;

  stream_mux_n #(.N(N), .W(W)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .s(s), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch)
  );

  stream_mux_n #(.N(3), .W(W)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
    .s(s3), .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready3), .out_ch(out_ch3)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Channel the rules grant this cycle, or -1 when nobody is granted.
  function automatic int model_grant(input logic [N-1:0] v, input logic [SW-1:0] sel, input int p);
`ifdef STREAM_MUX_RR_EN
    for (int i = 0; i < N; i++) begin
      if (v[(p + i) % N]) return (p + i) % N;
    end
    return -1;
`else
    return (int'(sel) < N) ? int'(sel) : -1;
`endif
  endfunction

  // Model state: contents of the one-entry output stage and the round-robin pointer.
  logic         mv;
  logic [W-1:0] md;
  int           mc;
  int           mptr;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mv   <= 1'b0;
      md   <= '0;
      mc   <= 0;
      mptr <= 0;
    end else begin : compare
      automatic int           g   = model_grant(in_valid, s, mptr);
      automatic logic         ld  = !mv || out_ready;
      automatic logic [N-1:0] exr = (g >= 0 && ld) ? (N'(1) << g) : '0;
      check("model_out_valid", {31'd0, out_valid}, {31'd0, mv});
      if (mv) begin
        check("model_out_data", {24'd0, out_data}, {24'd0, md});
        check("model_out_ch", {30'd0, out_ch}, mc);
      end
      check("model_in_ready", {28'd0, in_ready}, {28'd0, exr});
      if (g >= 0 && ld && in_valid[g]) begin
        mv   <= 1'b1;
        md   <= in_data[g*W +: W];
        mc   <= g;
        mptr <= (g + 1) % N;
      end else if (out_ready) begin
        mv <= 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    tick();
    tick();
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_out_data", {24'd0, out_data}, 32'd0);
    check("reset_out_ch", {30'd0, out_ch}, 32'd0);
    check("reset_in_ready", {28'd0, in_ready}, 32'd0);
    rst_n = 1'b1;

    // Async reset while a beat is held.
    s         = 2'd2;
    in_valid  = 4'b0100;
    in_data   = 32'h00C3_0000;
    out_ready = 1'b0;
    tick();
    check("midstream_valid", {31'd0, out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_out_valid", {31'd0, out_valid}, 32'd0);
    check("async_out_data", {24'd0, out_data}, 32'd0);
    check("async_out_ch", {30'd0, out_ch}, 32'd0);
    check("async_in_ready", {28'd0, in_ready}, 32'd0);
    in_valid = '0;
    tick();
    rst_n = 1'b1;

    // Single beat from channel 2, one cycle latency.
    s         = 2'd2;
    in_valid  = 4'b0100;
    in_data   = 32'h00A5_0000;
    out_ready = 1'b1;
    tick();
    check("beat_valid", {31'd0, out_valid}, 32'd1);
    check("beat_data", {24'd0, out_data}, 32'h0000_00A5);
    check("beat_ch", {30'd0, out_ch}, 32'd2);

    // Backpressure: held beat is immune to select and input changes.
    out_ready = 1'b0;
    in_valid  = 4'b1111;
    in_data   = 32'h4433_2211;
    tick();
    for (int i = 0; i < 4; i++) begin
      s = SW'(i);
      #1;
      check("stall_in_ready", {28'd0, in_ready}, 32'd0);
      check("stall_data", {24'd0, out_data}, 32'h0000_00A5);
      check("stall_ch", {30'd0, out_ch}, 32'd2);
      tick();
    end
    in_valid  = '0;
    out_ready = 1'b1;
    tick();
    check("drain_valid", {31'd0, out_valid}, 32'd0);

    // Streaming on channel 1 at full throughput.
    s        = 2'd1;
    in_valid = 4'b0010;
    for (int i = 1; i <= 4; i++) begin
      in_data = 32'(i) << 8;
      tick();
      check("stream_valid", {31'd0, out_valid}, 32'd1);
      check("stream_data", {24'd0, out_data}, 32'(i));
    end
    in_valid = '0;
    tick();
    check("stream_end_valid", {31'd0, out_valid}, 32'd0);

`ifndef STREAM_MUX_RR_EN
    // Out-of-range select on the three-channel instance.
    s3         = 2'd1;
    in_valid3  = 3'b111;
    in_data3   = 24'h77_3C_11;
    out_ready3 = 1'b0;
    tick();
    check("oor_load_valid", {31'd0, out_valid3}, 32'd1);
    check("oor_load_data", {24'd0, out_data3}, 32'h0000_003C);
    check("oor_load_ch", {30'd0, out_ch3}, 32'd1);
    s3 = 2'd3;
    #1;
    check("oor_stall_ready", {29'd0, in_ready3}, 32'd0);
    out_ready3 = 1'b1;
    #1;
    check("oor_open_ready", {29'd0, in_ready3}, 32'd0);
    tick();
    check("oor_drained", {31'd0, out_valid3}, 32'd0);
    tick();
    check("oor_stays_empty", {31'd0, out_valid3}, 32'd0);
    check("oor_idle_ready", {29'd0, in_ready3}, 32'd0);
    in_valid3 = '0;
`else
    // Round-robin order with all channels requesting, then with channels 1 and 3.
    apply_reset();
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("rr_all_ch", {30'd0, out_ch}, 32'(i % 4));
    end
    in_valid = '0;
    apply_reset();
    in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rr_odd_ch", {30'd0, out_ch}, (i % 2 == 1) ? 32'd3 : 32'd1);
    end
    in_valid = '0;
`endif

    // Randomized traffic, checked by the model every cycle.
    apply_reset();
    for (int i = 0; i < 1500; i++) begin
      in_valid  = N'($urandom);
      in_data   = $urandom;
      s         = SW'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
